// File: rtl/mmio_hub_pkg.sv
// Shared register map and status layout for the MMIO hub.
// Firmware and the testbench use the same offsets and bit positions.
package mmio_hub_pkg;

    localparam int unsigned MMIO_HALT      = 32'h000;
    localparam int unsigned MMIO_CYCLO     = 32'h004;
    localparam int unsigned MMIO_CYCHI     = 32'h008;
    localparam int unsigned MMIO_CH_STRIDE = 32'h100;
    localparam int unsigned MMIO_TXDATA    = 32'h0;
    localparam int unsigned MMIO_TXSTAT    = 32'h4;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTL_FLUSH   = 0;
    localparam int CTL_CLR_OVF = 1;

    typedef struct packed {
        logic ovf;
        logic full;
        logic empty;
    } chFlags_t;

    function automatic logic [31:0] statusWord(input logic [23:0] count, input chFlags_t flags);
        logic [31:0] w_word;
        w_word                       = '0;
        w_word[STAT_EMPTY]           = flags.empty;
        w_word[STAT_FULL]            = flags.full;
        w_word[STAT_OVF]             = flags.ovf;
        w_word[STAT_COUNT_LSB +: 24] = count;
        return w_word;
    endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// One TX channel: byte FIFO with push/pop/flush and a sticky overflow flag.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module mmio_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [7:0]             i_pushData,
    input  logic                   i_ready,
    input  logic                   i_flush,
    input  logic                   i_clrOvf,
    output logic                   o_valid,
    output logic [7:0]             o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_ovf,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_pushOk;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_pop    = !w_empty && i_ready;
    assign w_pushOk = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clearing wins over a coincident drop so firmware never loses its acknowledge.
    always_ff @(posedge clk) begin
        if (rst || i_clrOvf) begin
            r_ovf <= 1'b0;
        end else if (i_push && w_full && !w_pop && !i_flush) begin
            r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pushOk && !i_flush && !rst) r_mem[r_wrPtr] <= i_pushData;
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? 8'h00 : r_mem[r_rdPtr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_ovf   = r_ovf;
    assign o_count = r_count;

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped IO slave: halt/exit-code register, 64-bit cycle counter with
// high-word shadow, and NCH buffered TX byte channels. Reads answer one cycle later.
module mmio_hub
    import mmio_hub_pkg::*;
#(
    parameter int         NCH   = 2,
    parameter int         DEPTH = 16,
    parameter logic [3:0] BASE  = 4'hf
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_oe,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_we,
    output logic [31:0]      mem_rdata,
    output logic             mem_ready,
    output logic [NCH-1:0]   tx_valid,
    output logic [8*NCH-1:0] tx_data,
    input  logic [NCH-1:0]   tx_ready,
    output logic             halt,
    output logic [31:0]      halt_code
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [63:0] r_cycle;
    logic [31:0] r_shadow;
    logic        r_halt;
    logic [31:0] r_haltCode;
    logic        r_ready;
    logic [31:0] r_rdata;

    logic        w_sel;
    logic        w_write;
    logic        w_read;
    logic [27:0] w_offset;
    logic [31:0] w_rdNext;
    logic        w_unusedAddrLsb;

    logic [NCH-1:0] w_dataHit;
    logic [NCH-1:0] w_statHit;
    logic [NCH-1:0] w_full;
    logic [NCH-1:0] w_empty;
    logic [NCH-1:0] w_ovf;
    logic [CW-1:0]  w_count [NCH];

    // Byte lane bits of the address carry no meaning for word registers.
    assign w_offset        = {mem_addr[27:2], 2'b00};
    assign w_unusedAddrLsb = ^mem_addr[1:0];
    assign w_sel           = mem_oe && (mem_addr[31:28] == BASE);
    assign w_write         = w_sel && (mem_we != 4'b0000);
    assign w_read          = w_sel && (mem_we == 4'b0000);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_dataHit[c] = (w_offset == 28'(MMIO_CH_STRIDE * (c + 1) + MMIO_TXDATA));
        assign w_statHit[c] = (w_offset == 28'(MMIO_CH_STRIDE * (c + 1) + MMIO_TXSTAT));

        mmio_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .i_push     (w_write && w_dataHit[c]),
            .i_pushData (mem_wdata[7:0]),
            .i_ready    (tx_ready[c]),
            .i_flush    (w_write && w_statHit[c] && mem_wdata[CTL_FLUSH]),
            .i_clrOvf   (w_write && w_statHit[c] && mem_wdata[CTL_CLR_OVF]),
            .o_valid    (tx_valid[c]),
            .o_data     (tx_data[8*c +: 8]),
            .o_full     (w_full[c]),
            .o_empty    (w_empty[c]),
            .o_ovf      (w_ovf[c]),
            .o_count    (w_count[c])
        );
    end

    always_comb begin
        w_rdNext = '0;
        if (w_offset == 28'(MMIO_HALT)) begin
            w_rdNext = r_haltCode;
        end else if (w_offset == 28'(MMIO_CYCLO)) begin
            w_rdNext = r_cycle[31:0];
        end else if (w_offset == 28'(MMIO_CYCHI)) begin
            w_rdNext = r_shadow;
        end
        for (int c = 0; c < NCH; c++) begin
            if (w_dataHit[c]) w_rdNext = {31'b0, !w_full[c]};
            if (w_statHit[c]) w_rdNext = statusWord(24'(w_count[c]),
                                                    chFlags_t'{ovf: w_ovf[c], full: w_full[c], empty: w_empty[c]});
        end
    end

    // Reading the low word freezes the high word so a 64-bit read is coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle    <= '0;
            r_shadow   <= '0;
            r_halt     <= 1'b0;
            r_haltCode <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            r_ready <= w_read;
            r_rdata <= w_read ? w_rdNext : 32'h0;
            if (w_read && w_offset == 28'(MMIO_CYCLO)) r_shadow <= r_cycle[63:32];
            if (w_write && w_offset == 28'(MMIO_HALT)) begin
                r_halt     <= 1'b1;
                r_haltCode <= mem_wdata;
            end
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign halt      = r_halt;
    assign halt_code = r_haltCode;

endmodule

// File: tb/tb_mmio_hub.sv
// Directed bench for mmio_hub: read responses and TX bytes are checked by
// monitors against scoreboard queues filled as stimulus is issued.
module tb_mmio_hub;
    import mmio_hub_pkg::*;

    localparam int NCH   = 2;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mem_oe = 1'b0;
    logic [31:0]      mem_addr = '0;
    logic [31:0]      mem_wdata = '0;
    logic [3:0]       mem_we = '0;
    logic [31:0]      mem_rdata;
    logic             mem_ready;
    logic [NCH-1:0]   tx_valid;
    logic [8*NCH-1:0] tx_data;
    logic [NCH-1:0]   tx_ready = '0;
    logic             halt;
    logic [31:0]      halt_code;

    mmio_hub #(.NCH(NCH), .DEPTH(DEPTH), .BASE(4'hf)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_oe    (mem_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .halt_code (halt_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t       sbq[$];
    logic [7:0] txq0[$];
    logic [7:0] txq1[$];
    int         total = 0;
    int         bad = 0;
    int         negCount = 0;
    bit         monEn = 1'b0;

    localparam logic [31:0] A_HALT  = 32'hf000_0000;
    localparam logic [31:0] A_CYCLO = 32'hf000_0004;
    localparam logic [31:0] A_CYCHI = 32'hf000_0008;
    localparam logic [31:0] A_CH0D  = 32'hf000_0100;
    localparam logic [31:0] A_CH0S  = 32'hf000_0104;
    localparam logic [31:0] A_CH1D  = 32'hf000_0200;
    localparam logic [31:0] A_CH1S  = 32'hf000_0204;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one bus request for exactly one sampling edge; entered and left at posedge+1.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                                 input string name, input logic [31:0] expData);
        mem_oe    = 1'b1;
        mem_addr  = addr;
        mem_we    = we;
        mem_wdata = wdata;
        if (we == 4'b0000 && addr[31:28] == 4'hf) sbq.push_back('{name, expData, negCount + 2});
        @(posedge clk);
        #1;
        mem_oe = 1'b0;
        mem_we = 4'b0000;
    endtask

    task automatic busRead(input logic [31:0] addr, input logic [31:0] expData, input string name);
        applyStimulus(addr, 4'b0000, 32'h0, name, expData);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(addr, 4'b1111, wdata, "wr", 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        negCount++;
        if (monEn) begin
            if (mem_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_ready", 64'(mem_rdata), 64'hffff_ffff_ffff_ffff);
                end else begin
                    e = sbq.pop_front();
                    checkOutput(e.name, 64'(mem_rdata), 64'(e.data));
                    checkOutput({e.name, "_latency"}, 64'(negCount), 64'(e.due));
                end
            end else begin
                checkOutput("rdata_idle", 64'(mem_rdata), 64'h0);
                if (sbq.size() > 0 && sbq[0].due <= negCount) begin
                    e = sbq.pop_front();
                    checkOutput({e.name, "_no_ready"}, 64'(mem_ready), 64'h1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (monEn && tx_valid[0] && tx_ready[0]) begin
            if (txq0.size() == 0) checkOutput("tx0_extra", 64'(tx_data[7:0]), 64'hffff);
            else checkOutput("tx0_data", 64'(tx_data[7:0]), 64'(txq0.pop_front()));
        end
        if (monEn && tx_valid[1] && tx_ready[1]) begin
            if (txq1.size() == 0) checkOutput("tx1_extra", 64'(tx_data[15:8]), 64'hffff);
            else checkOutput("tx1_data", 64'(tx_data[15:8]), 64'(txq1.pop_front()));
        end
    end

    initial begin
        $display("[TB] start");
        idle(3);
        monEn = 1'b1;
        checkOutput("rst_halt", 64'(halt), 64'h0);
        checkOutput("rst_halt_code", 64'(halt_code), 64'h0);
        checkOutput("rst_tx_valid", 64'(tx_valid), 64'h0);
        checkOutput("rst_tx_data", 64'(tx_data), 64'h0);
        checkOutput("rst_mem_ready", 64'(mem_ready), 64'h0);
        rst = 1'b0;

        // Counter starts at 0 in the first cycle out of reset.
        busRead(A_CYCLO, 32'd0, "cyclo_first");
        busRead(A_CYCLO, 32'd1, "cyclo_second");
        busRead(A_CYCHI, 32'd0, "cychi_shadow");
        busRead(A_HALT, 32'h0, "halt_code_rst");
        busRead(32'hf000_0010, 32'h0, "unmapped");
        busRead(32'he000_0004, 32'h0, "other_base");
        busRead(A_CH0D, 32'h1, "ch0_not_full");
        busRead(A_CH0S, 32'h1, "ch0_stat_empty");
        busRead(32'hf000_0300, 32'h0, "ch2_absent");

        tx_ready[0] = 1'b1;
        busWrite(A_CH0D, 32'h41); txq0.push_back(8'h41);
        busWrite(A_CH0D, 32'h42); txq0.push_back(8'h42);
        busWrite(A_CH0D, 32'h43); txq0.push_back(8'h43);
        idle(3);
        tx_ready[0] = 1'b0;
        checkOutput("tx0_drained_q", 64'(txq0.size()), 64'h0);
        checkOutput("tx0_valid_low", 64'(tx_valid[0]), 64'h0);

        for (int i = 0; i < 17; i++) begin
            busWrite(A_CH0D, 32'h60 + 32'(i));
            if (i < DEPTH) txq0.push_back(8'(8'h60 + i));
        end
        busRead(A_CH0S, 32'h0000_1006, "ch0_stat_full_ovf");
        busRead(A_CH0D, 32'h0, "ch0_full_data_rd");

        tx_ready[0] = 1'b1;
        busWrite(A_CH0D, 32'hAA);
        txq0.push_back(8'hAA);
        tx_ready[0] = 1'b0;
        busRead(A_CH0S, 32'h0000_1006, "ch0_stat_push_pop");

        tx_ready[0] = 1'b1;
        idle(11);
        tx_ready[0] = 1'b0;
        busRead(A_CH0S, 32'h0000_0504, "ch0_stat_five");
        busWrite(A_CH1D, 32'h55); txq1.push_back(8'h55);
        busWrite(A_CH1D, 32'h66); txq1.push_back(8'h66);
        busWrite(A_CH0S, 32'h3);
        txq0.delete();
        busRead(A_CH0S, 32'h1, "ch0_stat_flushed");
        busRead(A_CH1S, 32'h0000_0200, "ch1_stat_untouched");
        checkOutput("tx0_valid_flushed", 64'(tx_valid[0]), 64'h0);
        tx_ready[1] = 1'b1;
        idle(3);
        tx_ready[1] = 1'b0;
        checkOutput("tx1_drained_q", 64'(txq1.size()), 64'h0);
        checkOutput("tx1_valid_low", 64'(tx_valid[1]), 64'h0);

        busWrite(A_HALT, 32'hdead_beef);
        checkOutput("halt_set", 64'(halt), 64'h1);
        checkOutput("halt_code_set", 64'(halt_code), 64'hdead_beef);
        busRead(A_HALT, 32'hdead_beef, "halt_code_rd");
        busWrite(A_HALT, 32'h1234_5678);
        checkOutput("halt_sticky", 64'(halt), 64'h1);
        checkOutput("halt_code_over", 64'(halt_code), 64'h1234_5678);
        busWrite(A_CH0D, 32'h77); txq0.push_back(8'h77);
        busRead(A_CH0S, 32'h0000_0100, "ch0_works_halted");

        // A read issued together with reset must never be answered.
        rst = 1'b1;
        applyStimulus(A_HALT, 4'b0000, 32'h0, "cancelled", 32'h0);
        sbq.delete();
        checkOutput("rst_cancel_ready", 64'(mem_ready), 64'h0);
        checkOutput("rst_cancel_halt", 64'(halt), 64'h0);
        checkOutput("rst_fifo_lost", 64'(tx_valid), 64'h0);
        txq0.delete();
        idle(1);
        rst = 1'b0;
        busRead(A_CYCLO, 32'd0, "cyclo_after_rst");
        busRead(A_CH0S, 32'h1, "ch0_stat_after_rst");
        busRead(A_HALT, 32'h0, "halt_code_after_rst");

        for (int i = 0; i < 10 && sbq.size() > 0; i++) idle(1);
        idle(2);
        checkOutput("scoreboard_empty", 64'(sbq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
